led_matrix_pwm_ctrl: RTL

LED_MATRIX_PWM_CTRL -- requirements
Module: led_matrix_pwm_ctrl

---
 rtl/led_matrix_pwm_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/led_matrix_pwm_ctrl.sv
// Double-buffered LED matrix panel driver: pixel write port into one frame store,
// row/bit-plane scan with binary-weighted display times out of the other.
//
// state     | meaning
// BLANKED   | no valid display buffer yet, oeb held high
// SHIFT     | clocking COLS columns of the current row/plane, last column first
// LATCH     | one-cycle latch pulse, line switches to the current row
// DISPLAY   | oeb low for BASE_TICKS*2^plane cycles
module led_matrix_pwm_ctrl #(
  parameter int COLS       = 32,
  parameter int ROW_BITS   = 3,
  parameter int PWM_BITS   = 4,
  parameter int CLK_DIV    = 2,
  parameter int BASE_TICKS = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [31:0]         data_in,
  input  logic                data_in_en,
  input  logic                wr_sync,
  output logic                data_in_full,
  output logic                led_clk,
  output logic                lat,
  output logic                oeb,
  output logic                r1,
  output logic                g1,
  output logic                b1,
  output logic                r2,
  output logic                g2,
  output logic                b2,
  output logic [ROW_BITS-1:0] line,
  output logic                frame_done
);

  localparam int NROWS = 1 << ROW_BITS;
  localparam int NPIX  = 2 * NROWS * COLS;
  localparam int PW    = 3 * PWM_BITS;
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PL_W  = (PWM_BITS > 1) ? $clog2(PWM_BITS) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TMR_W = $clog2(BASE_TICKS << (PWM_BITS - 1)) + 1;

  typedef enum logic [1:0] {
    S_BLANKED = 2'd0,
    S_SHIFT   = 2'd1,
    S_LATCH   = 2'd2,
    S_DISPLAY = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [PW-1:0]       r_mem [2][NPIX];
  logic [PIX_W-1:0]    r_wr_ptr;
  logic                r_full;
  logic                r_disp_buf;
  logic                r_disp_valid;
  logic [ROW_BITS-1:0] r_row;
  logic [ROW_BITS-1:0] r_line;
  logic [PL_W-1:0]     r_plane;
  logic [COL_W-1:0]    r_col;
  logic [DIV_W-1:0]    r_div;
  logic                r_phase;
  logic [TMR_W-1:0]    r_timer;

  logic              w_wr_fire;
  logic              w_last_px;
  logic              w_disp_done;
  logic              w_last_plane;
  logic              w_last_row;
  logic              w_frame_end;
  logic              w_swap;
  logic [PW-1:0]     w_pix_wr;
  logic [PIX_W-1:0]  w_idx_up;
  logic [PIX_W-1:0]  w_idx_dn;
  logic [PW-1:0]     w_pix_up;
  logic [PW-1:0]     w_pix_dn;
  logic [PW-1:0]     w_bits_up;
  logic [PW-1:0]     w_bits_dn;
  logic              w_unused;

  // Stored pixel layout: B planes on top, R planes at the bottom, plane k at bit k of each field.
  assign w_pix_wr  = {data_in[23 -: PWM_BITS], data_in[15 -: PWM_BITS], data_in[7 -: PWM_BITS]};
  assign w_unused  = &{1'b0, data_in};
  assign w_wr_fire = data_in_en && !r_full && !wr_sync;
  assign w_last_px = (r_wr_ptr == PIX_W'(NPIX - 1));

  assign w_disp_done  = (r_state == S_DISPLAY) && (r_timer == '0);
  assign w_last_plane = (r_plane == PL_W'(PWM_BITS - 1));
  assign w_last_row   = (r_row == {ROW_BITS{1'b1}});
  assign w_frame_end  = w_disp_done && w_last_plane && w_last_row;
  assign w_swap       = r_full && (!r_disp_valid || w_frame_end);

  assign w_idx_up  = PIX_W'(int'(r_row) * COLS + int'(r_col));
  assign w_idx_dn  = PIX_W'((int'(r_row) + NROWS) * COLS + int'(r_col));
  assign w_pix_up  = r_mem[r_disp_buf][w_idx_up];
  assign w_pix_dn  = r_mem[r_disp_buf][w_idx_dn];
  assign w_bits_up = w_pix_up >> r_plane;
  assign w_bits_dn = w_pix_dn >> r_plane;

  assign data_in_full = r_full;
  assign line         = r_line;

  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[!r_disp_buf][r_wr_ptr] <= w_pix_wr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_full       <= 1'b0;
      r_disp_buf   <= 1'b0;
      r_disp_valid <= 1'b0;
    end else begin
      if (wr_sync) r_wr_ptr <= '0;
      else if (w_wr_fire) r_wr_ptr <= w_last_px ? '0 : r_wr_ptr + PIX_W'(1);
      if (w_wr_fire && w_last_px) r_full <= 1'b1;
      else if (w_swap) r_full <= 1'b0;
      if (w_swap) begin
        r_disp_buf   <= !r_disp_buf;
        r_disp_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_BLANKED;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    led_clk     = 1'b0;
    lat         = 1'b0;
    oeb         = 1'b1;
    frame_done  = 1'b0;
    {r1, g1, b1, r2, g2, b2} = 6'b0;
    case (r_state)
      S_BLANKED: if (w_swap) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        led_clk = r_phase;
        r1 = w_bits_up[0];
        g1 = w_bits_up[PWM_BITS];
        b1 = w_bits_up[2*PWM_BITS];
        r2 = w_bits_dn[0];
        g2 = w_bits_dn[PWM_BITS];
        b2 = w_bits_dn[2*PWM_BITS];
        if (r_phase && (r_div == '0) && (r_col == '0)) w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        lat         = 1'b1;
        w_state_nxt = S_DISPLAY;
      end
      S_DISPLAY: begin
        oeb        = 1'b0;
        frame_done = w_frame_end;
        if (w_disp_done) w_state_nxt = S_SHIFT;
      end
      default: w_state_nxt = S_BLANKED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row   <= '0;
      r_line  <= '0;
      r_plane <= '0;
      r_col   <= '0;
      r_div   <= '0;
      r_phase <= 1'b0;
      r_timer <= '0;
    end else begin
      case (r_state)
        S_BLANKED: begin
          if (w_swap) begin
            r_row   <= '0;
            r_plane <= '0;
            r_col   <= COL_W'(COLS - 1);
            r_div   <= DIV_W'(CLK_DIV - 1);
            r_phase <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (r_div != '0) begin
            r_div <= r_div - DIV_W'(1);
          end else if (!r_phase) begin
            r_phase <= 1'b1;
            r_div   <= DIV_W'(CLK_DIV - 1);
          end else begin
            r_phase <= 1'b0;
            r_div   <= DIV_W'(CLK_DIV - 1);
            if (r_col == '0) r_line <= r_row;
            else             r_col  <= r_col - COL_W'(1);
          end
        end
        S_LATCH: r_timer <= TMR_W'((BASE_TICKS << r_plane) - 1);
        S_DISPLAY: begin
          if (r_timer != '0) begin
            r_timer <= r_timer - TMR_W'(1);
          end else begin
            r_col   <= COL_W'(COLS - 1);
            r_div   <= DIV_W'(CLK_DIV - 1);
            r_phase <= 1'b0;
            // Row counter wraps naturally, so the frame boundary restarts at row 0.
            if (w_last_plane) begin
              r_plane <= '0;
              r_row   <= r_row + ROW_BITS'(1);
            end else begin
              r_plane <= r_plane + PL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
